multi_ch_clock_divider: RTL
===========================

// Module: multi_ch_clock_divider
// PURPOSE
//   N-channel runtime-programmable clock divider / tick generator for the 50 MHz system clock.
//   Each channel produces a one-cycle enable pulse (tick) every DIV clocks and a 50%-duty square wave (clk_out, period 2*DIV).
//   Divisors are written at run time through a valid/ready config port and applied glitch-free at the period boundary.
//   Feeds game/display timing (e.g. 10 Hz animation, debounce, blink) from one block instead of per-function dividers.
// PARAMETERS
//   N_CH     4          number of independent channels (1..16)
//   CNT_W    24         divisor/counter width; max divisor 2^CNT_W-1
//   CH_W     2          width of cfg_ch; must satisfy 2^CH_W >= N_CH
//   DEF_DIV  5000000    divisor loaded into every channel at reset (10 Hz tick, 5 Hz clk_out @ 50 MHz)
// PORTS
//   clk           in   1           system clock, 50 MHz
//   reset         in   1           asynchronous, active-high reset
//   ch_en         in   N_CH        per-channel run enable (level)
//   sync_restart  in   1           one-cycle pulse: phase-align all channels
//   cfg_valid     in   1           config write request
//   cfg_ready     out  1           config write accepted this cycle when cfg_valid & cfg_ready
//   cfg_ch        in   CH_W        target channel index
//   cfg_div       in   CNT_W       new divisor (ticks every cfg_div clocks; 0 = channel parked)
//   tick          out  N_CH        registered one-cycle pulse per channel period
//   clk_out       out  N_CH        registered square wave, toggles on every tick
//   pending       out  N_CH        shadow divisor written but not yet applied
// BEHAVIOUR
//   - Reset (async): cnt=0, div=DEF_DIV, shadow empty, tick=0, clk_out=0, pending=0; cfg_ready reflects pending=0.
//   - Per channel, running when ch_en[i]=1 and div!=0: cnt counts 0..div-1; on clock where cnt==div-1:
//       cnt<=0, tick<=1 (next cycle only), clk_out<=~clk_out. All outputs registered; no combinational path to tick/clk_out.
//   - First tick after enable/restart appears exactly div clocks later; tick spacing = div clocks; clk_out period = 2*div.
//   - div==1: tick held high every cycle, clk_out = clk/2. div==0: channel parked (cnt=0, tick=0, clk_out=0).
//   - ch_en[i]=0: cnt cleared to 0, tick=0, clk_out forced 0 next clock; shadow still accepted and applied immediately.
//   - Config: cfg_ready = ~pending[cfg_ch] (combinational from cfg_ch); cfg_ch >= N_CH -> cfg_ready=1, write dropped.
//   - Accepted write to running channel: shadow<=cfg_div, pending<=1; applied on the terminal-count clock
//       (div<=shadow, pending<=0); the tick ending the current period uses the OLD divisor.
//   - Accepted write to disabled or parked channel: div<=cfg_div same clock, pending stays 0.
//   - Write while pending: cfg_ready=0, writer must hold cfg_valid; no overwrite of shadow.
//   - sync_restart: all cnt<=0, clk_out<=0, tick<=0, pending shadows applied immediately, pending<=0.
//       Same-cycle accepted write: new cfg_div applied immediately (write wins over old shadow).
//   - sync_restart coinciding with terminal count: restart wins, no tick emitted that cycle.
//   - Counter compare uses full CNT_W; no wrap beyond div-1. Reset mid-operation returns all state to reset values.
// TESTING
//   1 reset release, ch_en=0001, DEF_DIV=5 (bench override) -> tick[0] every 5 clk, clk_out[0] period 10, first tick 5 clk after en.
//   2 ch0 div=5 running, write cfg_div=3 at cnt=1 -> pending=1, next tick at old spacing 5, then spacing 3; pending clears same clk.
//   3 while pending[0]=1, cfg_valid ch0 -> cfg_ready=0 until apply; write to ch1 same time accepted (cfg_ready=1).
//   4 ch0 div=5, ch1 div=7 running; pulse sync_restart -> both clk_out=0, next ticks at +5 and +7 clk, aligned.
//   5 div=1 -> tick constant 1, clk_out toggles each clk; div=0 -> tick=0, clk_out=0; ch_en drop mid-count -> clk_out 0 next clk.
//   6 assert reset mid-period (async, between edges) -> tick/clk_out/pending 0 immediately; div back to DEF_DIV.

Source files
------------

// File: rtl/multi_ch_clock_divider.sv
// multi_ch_clock_divider: N-channel programmable tick / square-wave divider.
// Ports: clk, reset (async high), ch_en, sync_restart, cfg_valid/cfg_ready/cfg_ch/cfg_div, tick, clk_out, pending.
module multi_ch_clock_divider #(
  parameter int          N_CH    = 4,
  parameter int          CNT_W   = 24,
  parameter int          CH_W    = 2,
  parameter int unsigned DEF_DIV = 5000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   ch_en,
  input  logic              sync_restart,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [N_CH-1:0]   tick,
  output logic [N_CH-1:0]   clk_out,
  output logic [N_CH-1:0]   pending
);

  localparam int NP = 1 << CH_W;

  logic [CNT_W-1:0] cnt    [N_CH];
  logic [CNT_W-1:0] div    [N_CH];
  logic [CNT_W-1:0] shadow [N_CH];

  logic [N_CH-1:0] run;
  logic [N_CH-1:0] tc;
  logic [N_CH-1:0] wr_hit;
  logic [NP-1:0]   pend_pad;

  // Unused channel indices always look ready so a stray write is dropped
  // instead of stalling the writer.
  always_comb begin
    pend_pad = '0;
    pend_pad[N_CH-1:0] = pending;
    cfg_ready = (32'(cfg_ch) >= N_CH) | ~pend_pad[cfg_ch];
    for (int i = 0; i < N_CH; i++) begin
      run[i]    = ch_en[i] & (div[i] != '0);
      tc[i]     = run[i] & (cnt[i] == div[i] - CNT_W'(1));
      wr_hit[i] = cfg_valid & ~pending[i] & (32'(cfg_ch) == i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt[i]     <= '0;
        div[i]     <= CNT_W'(DEF_DIV);
        shadow[i]  <= '0;
        tick[i]    <= 1'b0;
        clk_out[i] <= 1'b0;
        pending[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (sync_restart) begin
          // A same-cycle write beats the older shadow value.
          cnt[i]     <= '0;
          tick[i]    <= 1'b0;
          clk_out[i] <= 1'b0;
          pending[i] <= 1'b0;
          if (wr_hit[i])
            div[i] <= cfg_div;
          else if (pending[i])
            div[i] <= shadow[i];
        end else if (!run[i]) begin
          // Idle channel: no period boundary to wait for.
          cnt[i]     <= '0;
          tick[i]    <= 1'b0;
          clk_out[i] <= 1'b0;
          if (wr_hit[i]) begin
            div[i] <= cfg_div;
          end else if (pending[i]) begin
            div[i]     <= shadow[i];
            pending[i] <= 1'b0;
          end
        end else begin
          if (tc[i]) begin
            cnt[i]     <= '0;
            tick[i]    <= 1'b1;
            clk_out[i] <= ~clk_out[i];
            if (pending[i]) begin
              div[i]     <= shadow[i];
              pending[i] <= 1'b0;
            end
          end else begin
            cnt[i]  <= cnt[i] + CNT_W'(1);
            tick[i] <= 1'b0;
          end
          // wr_hit implies no shadow outstanding, so this never
          // collides with the apply above.
          if (wr_hit[i]) begin
            shadow[i]  <= cfg_div;
            pending[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule
